// File: rtl/dmem_dma_arbiter_pkg.sv
// Shared widths, state/mode encodings and memory request payload for the DMEM/DMA arbiter.
package dmem_dma_arbiter_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned STARVE_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_FILL = 1'b0,
        MODE_COPY = 1'b1
    } mode_e;

    // One access presented to the single-port data memory.
    typedef struct packed {
        logic             we;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } mem_req_t;

    // Force a byte address onto a word boundary.
    function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] a);
        return a & ~WIDTH'(3);
    endfunction

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational grant decision and memory-side mux between the CPU and the DMA engine.
module dmem_port_mux
    import dmem_dma_arbiter_pkg::*;
(
    input  logic             dma_active,
    input  logic             starve_hit,
    input  logic             cpu_memread,
    input  logic             cpu_memwrite,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  mem_req_t         dma_req,
    output logic             dma_grant,
    output logic             cpu_stall,
    output mem_req_t         mem_req
);

    logic cpu_req;

    // CPU wins unless it is idle or the DMA has been starved to the limit.
    always_comb begin
        cpu_req   = cpu_memread | cpu_memwrite;
        dma_grant = dma_active & (~cpu_req | starve_hit);
        cpu_stall = cpu_req & dma_grant;
        if (dma_grant) begin
            mem_req = dma_req;
        end else begin
            mem_req.we   = cpu_memwrite;
            mem_req.addr = cpu_addr;
            mem_req.data = cpu_wdata;
        end
    end

endmodule

// File: rtl/dmem_dma_arbiter.sv
// Data-memory port arbiter with a fill/copy DMA engine; CPU has priority with a starvation limit.
module dmem_dma_arbiter
    import dmem_dma_arbiter_pkg::*;
#(
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_memread,
    input  logic             cpu_memwrite,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_stall,
    input  logic             dma_start,
    input  logic             dma_mode,
    input  logic [WIDTH-1:0] dma_src,
    input  logic [WIDTH-1:0] dma_dst,
    input  logic [LEN_W-1:0] dma_len,
    input  logic [WIDTH-1:0] dma_fill_val,
    input  logic             dma_abort,
    output logic             dma_busy,
    output logic             dma_done,
    output logic             dma_aborted,
    output logic             mem_memwrite,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_data_in,
    input  logic [WIDTH-1:0] mem_readdata
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [WIDTH-1:0]    src_q, src_d;
    logic [WIDTH-1:0]    dst_q, dst_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;

    logic     dma_active;
    logic     starve_hit;
    logic     dma_grant;
    mem_req_t dma_req;
    mem_req_t mem_req;

    // DMA-side request derived from the current engine state.
    always_comb begin
        dma_active   = (state_q == ST_READ) || (state_q == ST_WRITE);
        starve_hit   = (starve_q == STARVE_W'(STARVE_MAX));
        dma_req.we   = (state_q == ST_WRITE);
        dma_req.addr = (state_q == ST_READ) ? src_q : dst_q;
        dma_req.data = (mode_q == MODE_COPY) ? data_q : fill_q;
    end

    dmem_port_mux u_mux (
        .dma_active   (dma_active),
        .starve_hit   (starve_hit),
        .cpu_memread  (cpu_memread),
        .cpu_memwrite (cpu_memwrite),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .dma_req      (dma_req),
        .dma_grant    (dma_grant),
        .cpu_stall    (cpu_stall),
        .mem_req      (mem_req)
    );

    assign mem_memwrite = mem_req.we;
    assign mem_address  = mem_req.addr;
    assign mem_data_in  = mem_req.data;
    assign cpu_rdata    = mem_readdata;
    assign dma_busy     = busy_q;
    assign dma_done     = done_q;
    assign dma_aborted  = aborted_q;

    // Next-state, address/count update and starvation tracking.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        fill_d    = fill_q;
        data_d    = data_q;
        starve_d  = starve_q;
        aborted_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The count only measures contention within one transfer.
                starve_d = '0;
                if (dma_start) begin
                    mode_d = mode_e'(dma_mode);
                    src_d  = word_align(dma_src);
                    dst_d  = word_align(dma_dst);
                    rem_d  = dma_len;
                    fill_d = dma_fill_val;
                    if (dma_len == '0) begin
                        state_d = ST_DONE;
                    end else if (mode_e'(dma_mode) == MODE_COPY) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if (dma_grant) begin
                    data_d  = mem_readdata;
                    src_d   = src_q + WIDTH'(4);
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (dma_grant) begin
                    dst_d = dst_q + WIDTH'(4);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (mode_q == MODE_COPY) begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (dma_active) begin
            starve_d = dma_grant ? '0 : starve_q + STARVE_W'(1);
            // Abort wins over normal completion; a granted access this cycle still lands.
            if (dma_abort) begin
                state_d   = ST_DONE;
                aborted_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_FILL;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            fill_q    <= '0;
            data_q    <= '0;
            starve_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            fill_q    <= fill_d;
            data_q    <= data_d;
            starve_q  <= starve_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

endmodule
